// File: rtl/tempest_mem_pkg.sv
// ============================================================================
// Module : tempest_mem_pkg
// Brief  : Shared memory-subsystem widths and write-buffer FSM state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package tempest_mem_pkg;

  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module : wb_fifo
// Brief  : Posted-write storage with youngest-entry address match lookup.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wb_fifo
  import tempest_mem_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [ADDR_WIDTH-1:0]    push_addr,
  input  logic [DATA_WIDTH-1:0]    push_data,
  input  logic                     pop,
  output logic [ADDR_WIDTH-1:0]    head_addr,
  output logic [DATA_WIDTH-1:0]    head_data,
  input  logic [ADDR_WIDTH-1:0]    lookup_addr,
  output logic                     hit,
  output logic [DATA_WIDTH-1:0]    hit_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_INC = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_INC = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W:0]        r_count;
  logic [PTR_W-1:0]      w_idx;

  always_ff @(posedge clk) begin
    if (push) begin
      r_addr_mem[r_wr_ptr] <= push_addr;
      r_data_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PTR_INC;
      if (pop)  r_rd_ptr <= r_rd_ptr + PTR_INC;
      case ({push, pop})
        2'b10:   r_count <= r_count + CNT_INC;
        2'b01:   r_count <= r_count - CNT_INC;
        default: r_count <= r_count;
      endcase
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    w_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rd_ptr + PTR_W'(i);
      if ((i < int'(r_count)) && (r_addr_mem[w_idx] == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = r_data_mem[w_idx];
      end
    end
  end

  assign head_addr = r_addr_mem[r_rd_ptr];
  assign head_data = r_data_mem[r_rd_ptr];
  assign count     = r_count;
  assign full      = (r_count == CNT_MAX);
  assign empty     = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/dcache_write_buffer.sv
// ============================================================================
// Module : dcache_write_buffer
// Brief  : Posted-write buffer between dcache and memory with read forwarding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dcache_write_buffer
  import tempest_mem_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    c_req,
  input  logic                    c_we,
  input  logic [ADDR_WIDTH-1:0]   c_addr,
  input  logic [DATA_WIDTH-1:0]   c_wdata,
  output logic                    c_ready,
  output logic [DATA_WIDTH-1:0]   c_rdata,
  output logic                    m_req,
  output logic                    m_we,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  input  logic                    m_ready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  output logic [$clog2(DEPTH):0]  wb_count,
  output logic                    wb_empty
);

  wb_state_t             r_state;
  logic                  r_c_ready;
  logic [DATA_WIDTH-1:0] r_c_rdata;
  logic                  r_m_req;
  logic                  r_m_we;
  logic [ADDR_WIDTH-1:0] r_m_addr;
  logic [DATA_WIDTH-1:0] r_m_wdata;

  logic                  w_cache_new;
  logic                  w_hit;
  logic [DATA_WIDTH-1:0] w_hit_data;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fwd;
  logic                  w_miss;

  // A held read miss stays visible while its memory read is outstanding.
  assign w_cache_new = c_req && !r_c_ready && (r_state != READ) && (r_state != RESP);
  assign w_pop       = (r_state == DRAIN) && m_ready;
  assign w_push      = w_cache_new && c_we && (!w_full || w_pop);
  assign w_fwd       = w_cache_new && !c_we && w_hit;
  assign w_miss      = w_cache_new && !c_we && !w_hit;

  wb_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (w_push),
    .push_addr   (c_addr),
    .push_data   (c_wdata),
    .pop         (w_pop),
    .head_addr   (w_head_addr),
    .head_data   (w_head_data),
    .lookup_addr (c_addr),
    .hit         (w_hit),
    .hit_data    (w_hit_data),
    .count       (wb_count),
    .full        (w_full),
    .empty       (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_c_ready <= 1'b0;
      r_c_rdata <= '0;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
    end else begin
      r_c_ready <= w_push || w_fwd || ((r_state == READ) && m_ready);
      if (w_fwd) r_c_rdata <= w_hit_data;
      case (r_state)
        IDLE: begin
          // Read misses win over starting a new drain.
          if (w_miss) begin
            r_state  <= READ;
            r_m_req  <= 1'b1;
            r_m_we   <= 1'b0;
            r_m_addr <= c_addr;
          end else if (!w_empty) begin
            r_state   <= DRAIN;
            r_m_req   <= 1'b1;
            r_m_we    <= 1'b1;
            r_m_addr  <= w_head_addr;
            r_m_wdata <= w_head_data;
          end
        end
        DRAIN: begin
          if (m_ready) begin
            r_state <= IDLE;
            r_m_req <= 1'b0;
          end
        end
        READ: begin
          if (m_ready) begin
            r_state   <= RESP;
            r_m_req   <= 1'b0;
            r_c_rdata <= m_rdata;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign c_ready  = r_c_ready;
  assign c_rdata  = r_c_rdata;
  assign m_req    = r_m_req;
  assign m_we     = r_m_we;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign wb_empty = w_empty;

endmodule

`default_nettype wire

// File: tb/tb_dcache_write_buffer.sv
// ============================================================================
// Module : tb_dcache_write_buffer
// Brief  : Directed, table-driven bench for dcache_write_buffer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_dcache_write_buffer;

  localparam logic [31:0] RD_KEY = 32'hC0DE_0000;

  logic        clk;
  logic        rst_n;
  logic        c_req;
  logic        c_we;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_ready;
  logic [31:0] c_rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic [2:0]  wb_count;
  logic        wb_empty;

  int checks = 0;
  int errors = 0;

  dcache_write_buffer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .c_req    (c_req),
    .c_we     (c_we),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .c_ready  (c_ready),
    .c_rdata  (c_rdata),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_ready  (m_ready),
    .m_rdata  (m_rdata),
    .wb_count (wb_count),
    .wb_empty (wb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: fixed latency, real storage, unwritten words read as addr^RD_KEY.
  logic [31:0] mem_model [logic [31:0]];
  int mem_lat = 10;
  int lat_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b0;
      m_rdata <= '0;
      lat_cnt <= 0;
    end else begin
      m_ready <= 1'b0;
      if (m_req && !m_ready) begin
        if (lat_cnt >= mem_lat - 1) begin
          m_ready <= 1'b1;
          lat_cnt <= 0;
          if (m_we) mem_model[m_addr] = m_wdata;
          else m_rdata <= mem_model.exists(m_addr) ? mem_model[m_addr] : (m_addr ^ RD_KEY);
        end else begin
          lat_cnt <= lat_cnt + 1;
        end
      end
    end
  end

  // Transaction log, stability monitor and c_ready pulse counter.
  logic        log_we   [64];
  logic [31:0] log_addr [64];
  logic [31:0] log_data [64];
  int          log_cyc  [64];
  int          log_n = 0;
  int          rd_cnt = 0;
  int          stab_err = 0;
  int          cready_cnt = 0;
  logic        prev_req = 1'b0;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;

  always @(negedge clk) begin
    if (c_ready) cready_cnt++;
    if (m_req) begin
      if (!prev_req) begin
        cap_we = m_we; cap_addr = m_addr; cap_wdata = m_wdata;
      end else if ({m_we, m_addr, m_wdata} != {cap_we, cap_addr, cap_wdata}) begin
        stab_err++;
      end
      if (m_ready && log_n < 64) begin
        log_we[log_n]   = m_we;
        log_addr[log_n] = m_addr;
        log_data[log_n] = m_we ? m_wdata : m_rdata;
        log_cyc[log_n]  = cyc;
        if (!m_we) rd_cnt++;
        log_n++;
      end
    end
    prev_req = m_req;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  int          rdy_cyc;
  logic [2:0]  rdy_count;
  logic        rdy_mreq;

  // Starts and ends on a falling edge with c_ready low.
  task automatic cache_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int lat);
    c_req = 1'b1; c_we = we; c_addr = a; c_wdata = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!c_ready && lat < 300);
    if (!c_ready) begin
      checks++; errors++;
      $display("FAIL cache_op_timeout addr=%0h actual=no_ready expected=ready", a);
    end
    rd = c_rdata; rdy_cyc = cyc; rdy_count = wb_count; rdy_mreq = m_req;
    c_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(wb_empty && !m_req && !m_ready) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL wait_idle actual=busy expected=idle");
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [31:0] rd;
    int          lat;
    int          base;
    int          snap;

    vecs[0] = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1};
    vecs[1] = '{1'b1, 32'h0000_0104, 32'h0123_4567, 32'h0, 1};
    vecs[2] = '{1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0};
    vecs[3] = '{1'b0, 32'h0000_0104, 32'h0, 32'h0123_4567, 0};
    vecs[4] = '{1'b1, 32'h0000_0100, 32'hCAFE_F00D, 32'h0, 1};
    vecs[5] = '{1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 0};
    vecs[6] = '{1'b0, 32'h0000_0200, 32'h0, 32'h0000_0200 ^ RD_KEY, 0};
    vecs[7] = '{1'b1, 32'hFFFF_FFFC, 32'h5A5A_5A5A, 32'h0, 0};
    vecs[8] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 32'h5A5A_5A5A, 0};
    vecs[9] = '{1'b0, 32'h7FFF_FFFC, 32'h0, 32'h7FFF_FFFC ^ RD_KEY, 0};

    rst_n = 1'b0; c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_c_ready", 64'(c_ready), 64'd0);
    chk("rst_c_rdata", 64'(c_rdata), 64'd0);
    chk("rst_m_req", 64'(m_req), 64'd0);
    chk("rst_m_addr", 64'(m_addr), 64'd0);
    chk("rst_wb_count", 64'(wb_count), 64'd0);
    chk("rst_wb_empty", 64'(wb_empty), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single posted write into an empty buffer.
    mem_lat = 10;
    cache_op(1'b1, 32'h10, 32'hA5A5_A5A5, rd, lat);
    chk("w1_latency", 64'(lat), 64'd1);
    chk("w1_count", 64'(rdy_count), 64'd1);
    chk("w1_no_mreq_yet", 64'(rdy_mreq), 64'd0);
    wait_idle();
    chk("w1_mem_we", 64'(log_we[0]), 64'd1);
    chk("w1_mem_addr", 64'(log_addr[0]), 64'h10);
    chk("w1_mem_data", 64'(log_data[0]), 64'hA5A5_A5A5);

    // Same-address writes then read: youngest forwarded, no memory read.
    snap = rd_cnt;
    cache_op(1'b1, 32'h20, 32'h1111, rd, lat);
    cache_op(1'b1, 32'h20, 32'h2222, rd, lat);
    cache_op(1'b0, 32'h20, 32'h0, rd, lat);
    chk("fwd_rdata", 64'(rd), 64'h2222);
    chk("fwd_latency", 64'(lat), 64'd1);
    chk("fwd_no_mem_read", 64'(rd_cnt), 64'(snap));
    wait_idle();
    chk("fwd_mem_order", {log_data[log_n-2], log_data[log_n-1]}, {32'h1111, 32'h2222});

    // Table of mixed accesses with a short memory latency.
    mem_lat = 3;
    for (int i = 0; i < 10; i++) begin
      cache_op(vecs[i].we, vecs[i].addr, vecs[i].data, rd, lat);
      if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
      if (vecs[i].exp_lat != 0) chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
    end
    wait_idle();

    // Five writes into a four-entry buffer: the fifth waits for the first drain.
    mem_lat = 10;
    base = log_n;
    for (int i = 0; i < 5; i++) begin
      cache_op(1'b1, 32'(i * 4), 32'h1000 + 32'(i), rd, lat);
      if (i < 4) chk($sformatf("full_w%0d_latency", i), 64'(lat), 64'd1);
    end
    wait_idle();
    chk("full_w4_ready_cycle", 64'(rdy_cyc), 64'(log_cyc[base] + 1));
    for (int i = 0; i < 5; i++)
      chk($sformatf("full_order%0d", i), {31'd0, log_we[base+i], log_addr[base+i], log_data[base+i]},
          {31'd0, 1'b1, 32'(i * 4), 32'h1000 + 32'(i)});

    // Read miss behind an in-flight drain jumps ahead of remaining drains.
    base = log_n;
    cache_op(1'b1, 32'h300, 32'h3000, rd, lat);
    cache_op(1'b1, 32'h304, 32'h3004, rd, lat);
    cache_op(1'b1, 32'h308, 32'h3008, rd, lat);
    cache_op(1'b0, 32'h40, 32'h0, rd, lat);
    chk("miss_rdata", 64'(rd), 64'(32'h40 ^ RD_KEY));
    wait_idle();
    chk("miss_log0", {log_we[base], log_addr[base]}, {1'b1, 32'h300});
    chk("miss_log1", {log_we[base+1], log_addr[base+1]}, {1'b0, 32'h40});
    chk("miss_log2", {log_we[base+2], log_addr[base+2]}, {1'b1, 32'h304});
    chk("miss_log3", {log_we[base+3], log_addr[base+3]}, {1'b1, 32'h308});
    chk("mreq_stable", 64'(stab_err), 64'd0);

    // Reset in the middle of a drain with three entries buffered.
    cache_op(1'b1, 32'h500, 32'h5000, rd, lat);
    cache_op(1'b1, 32'h504, 32'h5004, rd, lat);
    cache_op(1'b1, 32'h508, 32'h5008, rd, lat);
    chk("rst_mid_mreq_before", 64'(m_req), 64'd1);
    chk("rst_mid_count_before", 64'(wb_count), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mreq", 64'(m_req), 64'd0);
    chk("rst_mid_empty", 64'(wb_empty), 64'd1);
    chk("rst_mid_count", 64'(wb_count), 64'd0);
    snap = log_n;
    base = cready_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("rst_mid_no_mem", 64'(log_n), 64'(snap));
    chk("rst_mid_no_cready", 64'(cready_cnt), 64'(base));
    chk("rst_mid_idle_mreq", 64'(m_req), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
